// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// It provides run/step/halt sequencing for the debug unit.
// It detects load-use hazards between ID and EX.
// It generates the stage enables and flush controls.
// It also keeps cycle and stall counters for debug readout.
module pipeline_ctrl #(
  parameter int NB_REG       = 5,
  parameter int NB_CYC       = 32,
  parameter int NB_STALL     = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_halt_instr,
  input  logic [NB_REG-1:0]   i_id_rs,
  input  logic [NB_REG-1:0]   i_id_rt,
  input  logic [NB_REG-1:0]   i_ex_rt,
  input  logic                i_ex_memRead,
  input  logic                i_branch_taken,
  output logic                o_pipe_en,
  output logic                o_pc_en,
  output logic                o_if_id_en,
  output logic                o_if_id_flush,
  output logic                o_id_ex_flush,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [NB_CYC-1:0]   o_cycle_cnt,
  output logic [NB_STALL-1:0] o_stall_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          drain_q, drain_d;
  logic [NB_CYC-1:0]   cycleCnt_q, cycleCnt_d;
  logic [NB_STALL-1:0] stallCnt_q, stallCnt_d;
  logic                loadUse;
  logic                stallEvent;

  assign loadUse = i_ex_memRead && (i_ex_rt != '0) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  // Next-state and combinational control outputs for the current state.
  // A taken branch outranks HALT, and HALT outranks a load-use stall.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_pipe_en     = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;
    stallEvent    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_run)       state_d = RUN;
        else if (i_step) state_d = STEP;
      end
      RUN, STEP: begin
        o_pipe_en = 1'b1;
        if (i_branch_taken) begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
        end else if (i_halt_instr) begin
          o_if_id_en    = 1'b1;
          o_if_id_flush = 1'b1;
        end else if (loadUse) begin
          o_id_ex_flush = 1'b1;
          stallEvent    = 1'b1;
        end else begin
          o_pc_en    = 1'b1;
          o_if_id_en = 1'b1;
        end
        if (!i_branch_taken && i_halt_instr) begin
          state_d = DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end else if (state_q == STEP || !i_run) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        o_pipe_en     = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b1;
        drain_d       = drain_q - 4'd1;
        if (drain_q <= 4'd1) begin
          state_d = HALTED;
          drain_d = 4'd0;
        end
      end
      HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
        drain_d = 4'd0;
      end
    endcase
  end

  // Saturating event counters: they hold at all-ones instead of wrapping.
  always_comb begin
    cycleCnt_d = cycleCnt_q;
    stallCnt_d = stallCnt_q;
    if (o_pipe_en && (cycleCnt_q != '1)) cycleCnt_d = cycleCnt_q + NB_CYC'(1);
    if (stallEvent && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + NB_STALL'(1);
  end

  // State, drain counter and event counters; reset aborts any operation.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      drain_q    <= 4'd0;
      cycleCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      cycleCnt_q <= cycleCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_cycle_cnt = cycleCnt_q;
  assign o_stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl.
// Inputs change on the falling edge, and outputs are checked 2 ns later.
// A second instance uses narrow counters to exercise saturation.
module tb_pipeline_ctrl;

  logic       clk;
  logic       i_rst_n;
  logic       i_run, i_step, i_halt_instr, i_ex_memRead, i_branch_taken;
  logic [4:0] i_id_rs, i_id_rt, i_ex_rt;

  logic        pipeEn, pcEn, ifIdEn, ifIdFlush, idExFlush, halted;
  logic [2:0]  state;
  logic [31:0] cycleCnt;
  logic [15:0] stallCnt;

  logic        sPipeEn, sPcEn, sIfIdEn, sIfIdFlush, sIdExFlush, sHalted;
  logic [2:0]  sState;
  logic [3:0]  sCycleCnt;
  logic [1:0]  sStallCnt;

  logic [4:0] ctrl;
  int         vecs;
  int         errs;
  int         expCycle;

  assign ctrl = {pipeEn, pcEn, ifIdEn, ifIdFlush, idExFlush};

  pipeline_ctrl dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step),
    .i_halt_instr(i_halt_instr), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_rt(i_ex_rt), .i_ex_memRead(i_ex_memRead), .i_branch_taken(i_branch_taken),
    .o_pipe_en(pipeEn), .o_pc_en(pcEn), .o_if_id_en(ifIdEn),
    .o_if_id_flush(ifIdFlush), .o_id_ex_flush(idExFlush), .o_state(state),
    .o_halted(halted), .o_cycle_cnt(cycleCnt), .o_stall_cnt(stallCnt)
  );

  pipeline_ctrl #(.NB_CYC(4), .NB_STALL(2)) dutSat (
    .clk(clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step),
    .i_halt_instr(i_halt_instr), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_rt(i_ex_rt), .i_ex_memRead(i_ex_memRead), .i_branch_taken(i_branch_taken),
    .o_pipe_en(sPipeEn), .o_pc_en(sPcEn), .o_if_id_en(sIfIdEn),
    .o_if_id_flush(sIfIdFlush), .o_id_ex_flush(sIdExFlush), .o_state(sState),
    .o_halted(sHalted), .o_cycle_cnt(sCycleCnt), .o_stall_cnt(sStallCnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clearHazards();
    i_halt_instr   = 1'b0;
    i_ex_memRead   = 1'b0;
    i_branch_taken = 1'b0;
    i_id_rs        = 5'd0;
    i_id_rt        = 5'd0;
    i_ex_rt        = 5'd0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_run   = 1'b0;
    i_step  = 1'b0;
    clearHazards();
    #2;
    vecs++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    vecs++; if (ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL reset_ctrl: got %b want 00000", ctrl); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    vecs++; if (cycleCnt !== 32'd0 || stallCnt !== 16'd0) begin errs++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", cycleCnt, stallCnt); end
    @(negedge clk);
    i_rst_n  = 1'b1;
    expCycle = 0;
  endtask

  task automatic test_run();
    i_run = 1'b1;
    #2;
    vecs++; if (state !== 3'd0 || ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL run_idle_cycle: got %0d/%b want 0/00000", state, ctrl); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #2;
      vecs++; if (state !== 3'd1) begin errs++; $display("[TB] FAIL run_state[%0d]: got %0d want 1", i, state); end
      vecs++; if (ctrl !== 5'b11100) begin errs++; $display("[TB] FAIL run_ctrl[%0d]: got %b want 11100", i, ctrl); end
      vecs++; if (cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL run_cycle[%0d]: got %0d want %0d", i, cycleCnt, expCycle); end
      expCycle++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    i_ex_memRead = 1'b1; i_ex_rt = 5'd8; i_id_rs = 5'd8;
    #2;
    vecs++; if (ctrl !== 5'b10001) begin errs++; $display("[TB] FAIL lu_rs_ctrl: got %b want 10001", ctrl); end
    expCycle++;
    @(negedge clk);
    clearHazards();
    #2;
    vecs++; if (stallCnt !== 16'd1) begin errs++; $display("[TB] FAIL lu_rs_cnt: got %0d want 1", stallCnt); end
    vecs++; if (ctrl !== 5'b11100) begin errs++; $display("[TB] FAIL lu_clear_ctrl: got %b want 11100", ctrl); end
    expCycle++;
    @(negedge clk);
    i_ex_memRead = 1'b1;
    #2;
    vecs++; if (ctrl !== 5'b11100) begin errs++; $display("[TB] FAIL lu_r0_ctrl: got %b want 11100", ctrl); end
    expCycle++;
    @(negedge clk);
    clearHazards();
    #2;
    vecs++; if (stallCnt !== 16'd1) begin errs++; $display("[TB] FAIL lu_r0_cnt: got %0d want 1", stallCnt); end
    vecs++; if (cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL lu_cycle: got %0d want %0d", cycleCnt, expCycle); end
    expCycle++;
    @(negedge clk);
    i_ex_memRead = 1'b1; i_ex_rt = 5'd5; i_id_rt = 5'd5; i_id_rs = 5'd3;
    #2;
    vecs++; if (ctrl !== 5'b10001) begin errs++; $display("[TB] FAIL lu_rt_ctrl: got %b want 10001", ctrl); end
    expCycle++;
    @(negedge clk);
    clearHazards();
    #2;
    vecs++; if (stallCnt !== 16'd2) begin errs++; $display("[TB] FAIL lu_rt_cnt: got %0d want 2", stallCnt); end
    expCycle++;
    @(negedge clk);
  endtask

  task automatic test_branch();
    i_ex_memRead = 1'b1; i_ex_rt = 5'd8; i_id_rs = 5'd8;
    i_branch_taken = 1'b1; i_halt_instr = 1'b1;
    #2;
    vecs++; if (ctrl !== 5'b11111) begin errs++; $display("[TB] FAIL br_ctrl: got %b want 11111", ctrl); end
    expCycle++;
    @(negedge clk);
    clearHazards();
    i_run = 1'b0;
    #2;
    vecs++; if (stallCnt !== 16'd2) begin errs++; $display("[TB] FAIL br_stall_cnt: got %0d want 2", stallCnt); end
    vecs++; if (state !== 3'd1) begin errs++; $display("[TB] FAIL br_still_run: got %0d want 1", state); end
    vecs++; if (ctrl !== 5'b11100) begin errs++; $display("[TB] FAIL run_last_ctrl: got %b want 11100", ctrl); end
    expCycle++;
    @(negedge clk);
    #2;
    vecs++; if (state !== 3'd0 || ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL run_stop: got %0d/%b want 0/00000", state, ctrl); end
    vecs++; if (cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL run_stop_cycle: got %0d want %0d", cycleCnt, expCycle); end
    @(negedge clk);
  endtask

  task automatic test_step();
    i_rst_n = 1'b0;
    #2;
    i_rst_n  = 1'b1;
    expCycle = 0;
    @(negedge clk);
    i_step = 1'b1;
    #2;
    vecs++; if (state !== 3'd0 || ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL step_pre: got %0d/%b want 0/00000", state, ctrl); end
    @(negedge clk);
    #2;
    vecs++; if (state !== 3'd2 || ctrl !== 5'b11100) begin errs++; $display("[TB] FAIL step_cycle: got %0d/%b want 2/11100", state, ctrl); end
    expCycle++;
    @(negedge clk);
    i_step = 1'b0;
    #2;
    vecs++; if (state !== 3'd0 || ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL step_done: got %0d/%b want 0/00000", state, ctrl); end
    vecs++; if (cycleCnt !== 32'd1) begin errs++; $display("[TB] FAIL step_cycle_cnt: got %0d want 1", cycleCnt); end
    @(negedge clk);
    #2;
    vecs++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL step_stays_idle: got %0d want 0", state); end
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    i_ex_memRead = 1'b1; i_ex_rt = 5'd9; i_id_rs = 5'd9;
    #2;
    vecs++; if (state !== 3'd2 || ctrl !== 5'b10001) begin errs++; $display("[TB] FAIL step_stall: got %0d/%b want 2/10001", state, ctrl); end
    expCycle++;
    @(negedge clk);
    clearHazards();
    #2;
    vecs++; if (state !== 3'd0 || stallCnt !== 16'd1) begin errs++; $display("[TB] FAIL step_stall_done: got %0d/%0d want 0/1", state, stallCnt); end
    vecs++; if (cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL step_stall_cycle: got %0d want %0d", cycleCnt, expCycle); end
    i_run = 1'b1; i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    #2;
    vecs++; if (state !== 3'd1) begin errs++; $display("[TB] FAIL run_beats_step: got %0d want 1", state); end
    expCycle++;
    @(negedge clk);
  endtask

  task automatic test_halt();
    i_halt_instr = 1'b1;
    #2;
    vecs++; if (state !== 3'd1 || ctrl !== 5'b10110) begin errs++; $display("[TB] FAIL halt_id: got %0d/%b want 1/10110", state, ctrl); end
    expCycle++;
    @(negedge clk);
    i_halt_instr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      vecs++; if (state !== 3'd3 || ctrl !== 5'b10110) begin errs++; $display("[TB] FAIL drain[%0d]: got %0d/%b want 3/10110", i, state, ctrl); end
      expCycle++;
      @(negedge clk);
    end
    #2;
    vecs++; if (state !== 3'd4 || halted !== 1'b1) begin errs++; $display("[TB] FAIL halted: got %0d/%b want 4/1", state, halted); end
    vecs++; if (ctrl !== 5'b00000) begin errs++; $display("[TB] FAIL halted_ctrl: got %b want 00000", ctrl); end
    vecs++; if (cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL halt_cycle: got %0d want %0d", cycleCnt, expCycle); end
    i_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      vecs++; if (state !== 3'd4 || cycleCnt !== 32'(expCycle)) begin errs++; $display("[TB] FAIL halted_sticky[%0d]: got %0d/%0d want 4/%0d", i, state, cycleCnt, expCycle); end
    end
    i_step = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    i_rst_n = 1'b0;
    #2;
    i_rst_n  = 1'b1;
    expCycle = 0;
    @(negedge clk);
    @(negedge clk);
    i_halt_instr = 1'b1;
    @(negedge clk);
    i_halt_instr = 1'b0;
    #2;
    vecs++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL mid_drain_entry: got %0d want 3", state); end
    @(negedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    vecs++; if (state !== 3'd0 || ctrl !== 5'b00000 || halted !== 1'b0) begin errs++; $display("[TB] FAIL async_reset: got %0d/%b/%b want 0/00000/0", state, ctrl, halted); end
    vecs++; if (cycleCnt !== 32'd0 || stallCnt !== 16'd0) begin errs++; $display("[TB] FAIL async_reset_cnt: got %0d/%0d want 0/0", cycleCnt, stallCnt); end
    @(negedge clk);
    i_run   = 1'b0;
    i_rst_n = 1'b1;
    clearHazards();
    #2;
    expCycle = 0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    i_run = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    expCycle += 20;
    i_ex_memRead = 1'b1; i_ex_rt = 5'd4; i_id_rs = 5'd4;
    repeat (5) @(negedge clk);
    expCycle += 5;
    clearHazards();
    i_run = 1'b0;
    #2;
    vecs++; if (cycleCnt !== 32'(expCycle) || stallCnt !== 16'd5) begin errs++; $display("[TB] FAIL wide_cnt: got %0d/%0d want %0d/5", cycleCnt, stallCnt, expCycle); end
    vecs++; if (sCycleCnt !== 4'd15) begin errs++; $display("[TB] FAIL sat_cycle: got %0d want 15", sCycleCnt); end
    vecs++; if (sStallCnt !== 2'd3) begin errs++; $display("[TB] FAIL sat_stall: got %0d want 3", sStallCnt); end
    @(negedge clk);
  endtask

  // Runs each scenario in order, then prints the summary.
  initial begin
    vecs = 0;
    errs = 0;
    expCycle = 0;
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_step();
    test_halt();
    test_reset_mid_drain();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
